mw_add_seq: RTL and testbench
=============================

# mw_add_seq

Sequential multi-word adder that time-shares one 16-bit adder core (rca16b) to add operands of 16*WORDS bits, one 16-bit limb per clock with a registered ripple carry between limbs. Sits between a requester and the 16-bit adder datapath. It sequences operand limbs into the core and carries between limbs. It presents the full-width result through a valid/ready handshake.

## Interface
- WORDS, 4, number of 16-bit limbs; operand width N = 16*WORDS; legal 2..16
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start_valid  input  1  requester has an operation
- start_ready  output  1  block accepts an operation (high only in IDLE)
- a  input  N  operand A, sampled at acceptance
- b  input  N  operand B, sampled at acceptance
- cin  input  1  carry/borrow in, sampled at acceptance
- op  input  1  0 = add, 1 = subtract (only with MW_ADD_SEQ_SUB_EN), sampled at acceptance
- res_valid  output  1  sum/cout hold a completed result
- res_ready  input  1  consumer takes result
- sum  output  N  registered result
- cout  output  1  registered final carry out of limb WORDS-1
- busy  output  1  high in RUN or DONE

Clock is clk. Reset is synchronous, active-low, named rst_n.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: latch a, b and op.
  - Carry register loads cin XOR (op & sub-enable).
  - Limb index idx=0. Go to RUN.
- RUN:
  - Each cycle drive the core with a[16*idx+:16].
  - Drive the B input with b[16*idx+:16], inverted when subtracting.
  - Carry input comes from the carry register.
  - Write the core sum to sum[16*idx+:16] and the core carry-out to the carry register. Increment idx.
  - When idx==WORDS-1, also load cout from the core carry-out and go to DONE.
- DONE:
  - res_valid=1.
  - sum and cout stay stable until res_valid&&res_ready, then go to IDLE.
  - sum and cout keep their values in IDLE until the next RUN overwrites them limb by limb.
- Arithmetic:
  - Add: {cout,sum} = a + b + cin.
  - Subtract: {cout,sum} = a + ~b + ~cin, i.e. a - b - cin. cout=1 means no borrow.
  - No overflow detection; the result wraps mod 2^N.
- start_valid is ignored outside IDLE. a, b, cin and op may change freely after acceptance.
- res_ready outside DONE has no effect.
- Reset:
  - Any clk edge with rst_n=0 forces IDLE, idx=0, carry=0, sum=0, cout=0.
  - This aborts any operation in progress. No res_valid is produced for an aborted operation.

## Timing
- Reset values: start_ready=1 (IDLE), res_valid=0, busy=0, sum=0, cout=0.
- Acceptance edge = E0. Limb i is written at edge E0+1+i.
- DONE is entered at edge E0+WORDS. res_valid is high from the cycle after E0+WORDS. Latency is WORDS cycles; for WORDS=4, res_valid rises 4 cycles after acceptance.
- The result handshake edge returns to IDLE. The earliest next acceptance is the following edge, giving a minimum initiation interval of WORDS+2 cycles.
- start_ready, res_valid and busy are decoded from registered state only. There is no combinational path from any input to any output.
- Critical path: one 16-bit adder plus the limb mux; independent of WORDS.

## Configuration
- MW_ADD_SEQ_SUB_EN defined:
  - op selects add or subtract.
  - The B limb is XORed with {16{op}*}.
  - The initial carry is cin^op.
- Not defined:
  - The op port is still present but ignored.
  - No inversion logic; the block always adds.
  - The initial carry is cin.

## Test plan (WORDS=4)
- a=64'h0000_0000_0000_FFFF, b=1, cin=0 → res_valid 4 cycles after accept; sum=64'h0000_0000_0001_0000, cout=0.
- a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1. Carry must propagate through all four limbs.
- a=64'hAAAA_AAAA_AAAA_AAAA, b=64'h5555_5555_5555_5555, cin=0 then cin=1 → sum=all F with cout=0, then sum=0 with cout=1.
- res_ready held low 3 cycles in DONE while start_valid=1 with new operands → res_valid, sum and cout stay stable; start_ready=0; the new op is accepted only one edge after the result handshake.
- rst_n low for one edge while idx=2 → next cycle IDLE, res_valid=0, busy=0, sum=0. A following add of 1+1 returns sum=2.
- op=1, a=0, b=1, cin=0 → with MW_ADD_SEQ_SUB_EN: sum=64'hFFFF_FFFF_FFFF_FFFF, cout=0. Without it: sum=1, cout=0.

Source files
------------

// File: rtl/mw_add_seq.sv
// mw_add_seq: multi-word adder that adds one 16-bit limb per clock through a single shared rca16b core
// Ports: clk, rst_n (sync, active-low); start_valid/start_ready with a, b, cin, op sampled at acceptance;
//        res_valid/res_ready with registered sum and cout; busy is high in RUN or DONE.
// Define MW_ADD_SEQ_SUB_EN to make op select subtract (a - b - cin); otherwise op is ignored.
module rca16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {16'd0, ci};
endmodule

module mw_add_seq #(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic              cin,
  input  logic              op,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [16*WORDS-1:0] sum,
  output logic              cout,
  output logic              busy
);
  localparam int N = 16 * WORDS;
  localparam int IW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [N-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic c_q, c0, core_c, last;
  logic [15:0] b_l, core_s;
`ifdef MW_ADD_SEQ_SUB_EN
  logic op_q;
  always_ff @(posedge clk)
    if (start_valid && start_ready) op_q <= op;
  // Subtraction is a + ~b with the borrow-in folded into the initial carry.
  assign b_l = b_q[16*idx +: 16] ^ {16{op_q}};
  assign c0 = cin ^ op;
`else
  logic op_unused;
  assign op_unused = op;
  assign b_l = b_q[16*idx +: 16];
  assign c0 = cin;
`endif
  rca16b u_core (
    .a (a_q[16*idx +: 16]),
    .b (b_l),
    .ci(c_q),
    .s (core_s),
    .co(core_c)
  );
  assign last = idx == IW'(WORDS - 1);
  assign start_ready = state == IDLE;
  assign res_valid = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE && start_valid) ? RUN :
                (state == RUN && last) ? DONE :
                (state == DONE && res_ready) ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (start_valid && start_ready) begin
      a_q <= a;
      b_q <= b;
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      c_q <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start_valid) begin
        c_q <= c0;
        idx <= '0;
      end
      if (state == RUN) begin
        sum[16*idx +: 16] <= core_s;
        c_q <= core_c;
        idx <= idx + 1'b1;
        if (last) cout <= core_c;
      end
    end
endmodule

// File: tb/tb_mw_add_seq.sv
// tb_mw_add_seq: directed scoreboard bench for mw_add_seq with WORDS=4
module tb_mw_add_seq;
  logic clk = 0;
  logic rst_n, start_valid, start_ready, cin, op, res_valid, res_ready, cout, busy;
  logic [63:0] a, b, sum;
  logic [64:0] exp_q[$];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  mw_add_seq #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin), .op(op), .res_valid(res_valid), .res_ready(res_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );
  function automatic void chk(string nm, logic [64:0] act, logic [64:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction
  always @(negedge clk)
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", {cout, sum}, 65'h0 - 65'h1);
      else chk("result", {cout, sum}, exp_q.pop_front());
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input logic [63:0] ta, input logic [63:0] tb_, input logic tc, input logic to,
                        input logic [64:0] e, input bit push);
    int n = 0;
    start_valid = 1; a = ta; b = tb_; cin = tc; op = to;
    while (!start_ready && n < 20) begin tick(); n++; end
    chk("accept_ready", {64'd0, start_ready}, 65'd1);
    if (push) exp_q.push_back(e);
    tick();
    start_valid = 0; a = '1; b = '1; cin = ~tc; op = ~to;
  endtask
  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
  endtask
  task automatic run(input logic [63:0] ta, input logic [63:0] tb_, input logic tc, input logic to,
                     input logic [64:0] e);
    int n;
    accept(ta, tb_, tc, to, e, 1);
    wait_res(n);
    chk("latency", 65'(n), 65'd4);
    tick();
    chk("idle_after", {62'd0, start_ready, res_valid, busy}, 65'b100);
    chk("hold_idle", {cout, sum}, e);
  endtask
  initial begin
    int n;
    rst_n = 0; start_valid = 0; res_ready = 1; a = 0; b = 0; cin = 0; op = 0;
    tick(); tick();
    rst_n = 1;
    chk("reset_ctl", {62'd0, start_ready, res_valid, busy}, 65'b100);
    chk("reset_out", {cout, sum}, 65'd0);
    run(64'h0000_0000_0000_FFFF, 64'd1, 0, 0, {1'b0, 64'h0000_0000_0001_0000});
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, {1'b1, 64'h0});
    run(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 0, 0, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    run(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1, 0, {1'b1, 64'h0});
    res_ready = 0;
    accept(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 0, 0, {1'b0, 64'h2345_6789_ABCD_F001}, 1);
    wait_res(n);
    chk("stall_latency", 65'(n), 65'd4);
    start_valid = 1; a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000; cin = 1; op = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_out", {cout, sum}, {1'b0, 64'h2345_6789_ABCD_F001});
      chk("stall_ctl", {62'd0, res_valid, start_ready, busy}, 65'b101);
    end
    res_ready = 1;
    exp_q.push_back({1'b1, 64'h1});
    tick();
    chk("hs_idle", {63'd0, start_ready, busy}, 65'b10);
    tick();
    chk("late_accept", {63'd0, start_ready, busy}, 65'b01);
    start_valid = 0;
    wait_res(n);
    chk("late_latency", 65'(n), 65'd4);
    tick();
    accept(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 65'd0, 0);
    tick(); tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("abort_ctl", {62'd0, start_ready, res_valid, busy}, 65'b100);
    chk("abort_out", {cout, sum}, 65'd0);
    run(64'd1, 64'd1, 0, 0, 65'd2);
`ifdef MW_ADD_SEQ_SUB_EN
    run(64'd0, 64'd1, 0, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    run(64'd10, 64'd3, 1, 1, {1'b1, 64'd6});
`else
    run(64'd0, 64'd1, 0, 1, {1'b0, 64'd1});
`endif
    tick(); tick();
    chk("queue_empty", 65'(exp_q.size()), 65'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
